aes_round_scheduler: RTL and testbench



---
 rtl/aes_sched_pkg.sv | 18 +
 rtl/aes_round_scheduler_if.sv | 32 +++
 rtl/aes_round_scheduler_rr_arbiter2.sv | 29 ++
 rtl/aes_round_scheduler.sv | 118 +++++++++++
 tb/tb_aes_round_scheduler.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES round scheduler.
// State encoding, channel ids and the round-count function.
package aes_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_e;

   localparam logic CH_ENC = 1'b0;
   localparam logic CH_DEC = 1'b1;

   function automatic logic [3:0] nr_of(input int unsigned key_x);
      return 4'(10 + 2 * key_x);
   endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Block-level stream bundle: encrypt/decrypt requests and the result.
// master = requesters/consumer side, slave = scheduler side.
interface aes_round_scheduler_if;

   logic         enc_valid;
   logic         enc_ready;
   logic [127:0] enc_data;
   logic         dec_valid;
   logic         dec_ready;
   logic [127:0] dec_data;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         res_is_dec;

   modport master (
      output enc_valid, enc_data,
      output dec_valid, dec_data,
      output res_ready,
      input  enc_ready, dec_ready,
      input  res_valid, res_data, res_is_dec
   );

   modport slave (
      input  enc_valid, enc_data,
      input  dec_valid, dec_data,
      input  res_ready,
      output enc_ready, dec_ready,
      output res_valid, res_data, res_is_dec
   );

endinterface

// File: rtl/aes_round_scheduler_rr_arbiter2.sv
// Two-request round-robin arbiter with a last-grant flag.
// Grant is combinational; the flag updates only on an accept.
module rr_arbiter2
   import aes_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_enc_i,
   input  logic req_dec_i,
   input  logic accept_i,
   output logic gnt_enc_o,
   output logic gnt_dec_o
);

   logic last_dec_q;

   assign gnt_enc_o = req_enc_i & (~req_dec_i | last_dec_q);
   assign gnt_dec_o = req_dec_i & (~req_enc_i | ~last_dec_q);

   // Starts as "decrypt went last" so encrypt wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_dec_q <= CH_DEC;
      end else if (accept_i) begin
         last_dec_q <= gnt_dec_o;
      end
   end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences a shared iterative AES round unit between an encrypt
// and a decrypt requester, one round per cycle, result on a handshake.
module aes_round_scheduler
   import aes_sched_pkg::*;
#(
   parameter int unsigned KEY_X = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_round_scheduler_if.slave io,
   output logic [127:0]         rnd_state,
   output logic                 rnd_decrypt,
   output logic [3:0]           rnd_idx,
   output logic [3:0]           rnd_key_idx,
   output logic                 rnd_first,
   output logic                 rnd_last,
   input  logic [127:0]         rnd_result,
   output logic                 busy
);

   localparam logic [3:0] NR = nr_of(KEY_X);

   fsm_e         fsm_q;
   logic [127:0] state_q;
   logic [127:0] res_data_q;
   logic [3:0]   round_q;
   logic         mode_q;
   logic         res_valid_q;
   logic         res_is_dec_q;

   logic         idle;
   logic         run;
   logic         gnt_enc;
   logic         gnt_dec;
   logic         enc_rdy;
   logic         dec_rdy;
   logic         accept;
   logic         mode_d;
   logic [127:0] load_d;

   assign idle = (fsm_q == IDLE);
   assign run  = (fsm_q == RUN);

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_enc_i (io.enc_valid),
      .req_dec_i (io.dec_valid),
      .accept_i  (accept),
      .gnt_enc_o (gnt_enc),
      .gnt_dec_o (gnt_dec)
   );

   assign enc_rdy = idle & gnt_enc;
   assign dec_rdy = idle & gnt_dec;
   assign accept  = enc_rdy | dec_rdy;
   assign mode_d  = gnt_dec ? CH_DEC : CH_ENC;
   assign load_d  = gnt_dec ? io.dec_data : io.enc_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q        <= IDLE;
         state_q      <= '0;
         res_data_q   <= '0;
         round_q      <= '0;
         mode_q       <= CH_ENC;
         res_valid_q  <= 1'b0;
         res_is_dec_q <= 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               if (accept) begin
                  state_q <= load_d;
                  mode_q  <= mode_d;
                  round_q <= '0;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               state_q <= rnd_result;
               // Counter parks at 0 so it never leaves 0..NR.
               if (round_q == NR) begin
                  round_q      <= '0;
                  res_data_q   <= rnd_result;
                  res_is_dec_q <= mode_q;
                  res_valid_q  <= 1'b1;
                  fsm_q        <= DONE;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            DONE: begin
               if (io.res_ready) begin
                  res_valid_q <= 1'b0;
                  fsm_q       <= IDLE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign io.enc_ready  = enc_rdy;
   assign io.dec_ready  = dec_rdy;
   assign io.res_valid  = res_valid_q;
   assign io.res_data   = res_data_q;
   assign io.res_is_dec = res_is_dec_q;

   assign rnd_state   = state_q;
   assign rnd_decrypt = run & mode_q;
   assign rnd_idx     = run ? round_q : 4'd0;
   assign rnd_key_idx = !run   ? 4'd0 :
                        mode_q ? NR - round_q : round_q;
   assign rnd_first   = run & (round_q == 4'd0);
   assign rnd_last    = run & (round_q == NR);
   assign busy        = !idle;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench: scheduler driving a behavioural AES round model,
// checked against the FIPS-197 AES-128 and AES-256 vectors.
module tb_aes_round_scheduler;

   typedef logic [14:0][127:0] rk_t;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128  =
      {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K256  =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_round_scheduler_if if0 ();
   aes_round_scheduler_if if2 ();

   logic [127:0] rs0, rr0, rs2, rr2;
   logic         rd0, rf0, rl0, bz0;
   logic         rd2, rf2, rl2, bz2;
   logic [3:0]   ri0, rki0, ri2, rki2;
   rk_t          rk0, rk2;

   aes_round_scheduler #(.KEY_X(0)) u0 (
      .clk         (clk),
      .rst         (rst),
      .io          (if0),
      .rnd_state   (rs0),
      .rnd_decrypt (rd0),
      .rnd_idx     (ri0),
      .rnd_key_idx (rki0),
      .rnd_first   (rf0),
      .rnd_last    (rl0),
      .rnd_result  (rr0),
      .busy        (bz0)
   );

   aes_round_scheduler #(.KEY_X(2)) u2 (
      .clk         (clk),
      .rst         (rst),
      .io          (if2),
      .rnd_state   (rs2),
      .rnd_decrypt (rd2),
      .rnd_idx     (ri2),
      .rnd_key_idx (rki2),
      .rnd_first   (rf2),
      .rnd_last    (rl2),
      .rnd_result  (rr2),
      .busy        (bz2)
   );

   // ---------------- AES reference round model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r, base, e;
      r = 8'h01;
      base = a;
      e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, base);
         base = gmul(base, base);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [15:0] d;
      d = {b, b} << k;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x;
      x = ginv(b);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isbox(input logic [7:0] b);
      return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
   endfunction

   function automatic logic [31:0] mixc(input logic [31:0] c, input logic [31:0] m);
      logic [31:0] o;
      logic [7:0]  acc;
      o = '0;
      for (int i = 0; i < 4; i++) begin
         acc = 8'h00;
         for (int j = 0; j < 4; j++)
            acc = acc ^ gmul(m[31-8*((j-i+4)%4) -: 8], c[31-8*j -: 8]);
         o[31-8*i -: 8] = acc;
      end
      return o;
   endfunction

   function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic dec,
                                            input logic first, input logic last,
                                            input logic [127:0] k);
      logic [7:0]   a [16];
      logic [127:0] x;
      logic [31:0]  m;
      if (first) return s ^ k;
      x = '0;
      for (int n = 0; n < 16; n++) a[n] = s[127-8*n -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            x[127-8*(r+4*c) -: 8] = dec ? isbox(a[r+4*((c-r+4)%4)])
                                        : sbox(a[r+4*((c+r)%4)]);
      m = dec ? 32'h0e0b0d09 : 32'h02030101;
      if (dec) x = x ^ k;
      if (!last)
         for (int c = 0; c < 4; c++) x[127-32*c -: 32] = mixc(x[127-32*c -: 32], m);
      if (!dec) x = x ^ k;
      return x;
   endfunction

   function automatic rk_t expand(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rk_t         rk;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      rk = '0;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
               t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rk;
   endfunction

   always_comb rr0 = aes_rnd(rs0, rd0, rf0, rl0, rk0[rki0]);
   always_comb rr2 = aes_rnd(rs2, rd2, rf2, rl2, rk2[rki2]);

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({bz0, if0.res_valid, if0.enc_ready, if0.dec_ready, rd0, rf0, rl0, if0.res_is_dec} !== 8'h00) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0", {bz0, if0.res_valid, if0.enc_ready, if0.dec_ready, rd0, rf0, rl0, if0.res_is_dec});
      end
      total++;
      if ({rs0, if0.res_data, ri0, rki0} !== '0) begin
         bad++;
         $display("FAIL reset_buses state=%h res=%h idx=%h kidx=%h exp=0", rs0, if0.res_data, ri0, rki0);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_encrypt();
      if0.enc_data = PT;
      if0.enc_valid = 1'b1;
      #1;
      total++;
      if ({if0.enc_ready, if0.dec_ready} !== 2'b10) begin
         bad++;
         $display("FAIL enc_grant got=%b exp=10", {if0.enc_ready, if0.dec_ready});
      end
      tick();
      if0.enc_valid = 1'b0;
      if0.enc_data = '0;
      #1;
      total++;
      if (rs0 !== PT) begin
         bad++;
         $display("FAIL enc_load got=%h exp=%h", rs0, PT);
      end
      for (int r = 0; r <= 10; r++) begin
         total++;
         if ({ri0, rki0, rf0, rl0, rd0, if0.res_valid, bz0} !==
             {4'(r), 4'(r), (r == 0), (r == 10), 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL enc_round r=%0d got idx=%0d kidx=%0d f=%b l=%b d=%b v=%b busy=%b",
                     r, ri0, rki0, rf0, rl0, rd0, if0.res_valid, bz0);
         end
         tick();
      end
      total++;
      if ({if0.res_valid, if0.res_is_dec, if0.res_data} !== {1'b1, 1'b0, CT128}) begin
         bad++;
         $display("FAIL enc_result v=%b dec=%b got=%h exp=%h", if0.res_valid, if0.res_is_dec, if0.res_data, CT128);
      end
      if0.res_ready = 1'b1;
      tick();
      if0.res_ready = 1'b0;
      #1;
      total++;
      if ({bz0, if0.res_valid} !== 2'b00) begin
         bad++;
         $display("FAIL enc_release got=%b exp=00", {bz0, if0.res_valid});
      end
   endtask

   task automatic test_decrypt();
      if0.dec_data = CT128;
      if0.dec_valid = 1'b1;
      #1;
      total++;
      if ({if0.enc_ready, if0.dec_ready} !== 2'b01) begin
         bad++;
         $display("FAIL dec_grant got=%b exp=01", {if0.enc_ready, if0.dec_ready});
      end
      tick();
      if0.dec_valid = 1'b0;
      #1;
      for (int r = 0; r <= 10; r++) begin
         total++;
         if ({ri0, rki0, rf0, rl0, rd0, if0.res_valid} !==
             {4'(r), 4'(10 - r), (r == 0), (r == 10), 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL dec_round r=%0d got idx=%0d kidx=%0d f=%b l=%b d=%b v=%b",
                     r, ri0, rki0, rf0, rl0, rd0, if0.res_valid);
         end
         tick();
      end
      total++;
      if ({if0.res_valid, if0.res_is_dec, if0.res_data} !== {1'b1, 1'b1, PT}) begin
         bad++;
         $display("FAIL dec_result v=%b dec=%b got=%h exp=%h", if0.res_valid, if0.res_is_dec, if0.res_data, PT);
      end
      if0.res_ready = 1'b1;
      tick();
      if0.res_ready = 1'b0;
      #1;
   endtask

   task automatic test_contention();
      int   t [3];
      logic ch [3];
      int   n;
      int   got;
      n = 0;
      got = 0;
      rst = 1'b1;
      if0.enc_data = PT;
      if0.dec_data = CT128;
      if0.enc_valid = 1'b1;
      if0.dec_valid = 1'b1;
      if0.res_ready = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 80 && got < 3; i++) begin
         total++;
         if (if0.enc_ready && if0.dec_ready) begin
            bad++;
            $display("FAIL cont_both_ready cycle=%0d got=11 exp=one-hot", cyc);
         end
         if (n < 3 && (if0.enc_ready || if0.dec_ready)) begin
            t[n] = cyc;
            ch[n] = if0.dec_ready;
            n++;
         end
         if (if0.res_valid) begin
            got++;
            total++;
            if (if0.res_data !== (if0.res_is_dec ? PT : CT128)) begin
               bad++;
               $display("FAIL cont_result dec=%b got=%h", if0.res_is_dec, if0.res_data);
            end
         end
         tick();
         if (n == 3) begin
            if0.enc_valid = 1'b0;
            if0.dec_valid = 1'b0;
         end
      end
      if0.res_ready = 1'b0;
      total++;
      if (n != 3 || got != 3) begin
         bad++;
         $display("FAIL cont_count accepts=%0d results=%0d exp=3/3", n, got);
      end else begin
         total++;
         if ({ch[0], ch[1], ch[2]} !== 3'b010) begin
            bad++;
            $display("FAIL cont_order got=%b exp=010", {ch[0], ch[1], ch[2]});
         end
         total++;
         if (t[1] - t[0] != 13 || t[2] - t[1] != 13) begin
            bad++;
            $display("FAIL cont_spacing got=%0d,%0d exp=13,13", t[1] - t[0], t[2] - t[1]);
         end
      end
      #1;
   endtask

   task automatic test_backpressure();
      int k;
      if0.enc_data = PT;
      if0.enc_valid = 1'b1;
      if0.res_ready = 1'b0;
      #1;
      total++;
      if (if0.enc_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept got=%b exp=1", if0.enc_ready);
      end
      tick();
      k = 0;
      while (!if0.res_valid && k < 30) begin
         tick();
         k++;
      end
      total++;
      if (if0.res_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_timeout got=%b exp=1", if0.res_valid);
      end
      for (int i = 0; i < 20; i++) begin
         total++;
         if ({if0.res_valid, bz0, if0.enc_ready, if0.res_data} !== {1'b1, 1'b1, 1'b0, CT128}) begin
            bad++;
            $display("FAIL bp_hold i=%0d v=%b busy=%b rdy=%b data=%h exp=%h",
                     i, if0.res_valid, bz0, if0.enc_ready, if0.res_data, CT128);
         end
         tick();
      end
      if0.res_ready = 1'b1;
      #1;
      total++;
      if (if0.enc_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_same_cycle got=%b exp=0", if0.enc_ready);
      end
      tick();
      if0.res_ready = 1'b0;
      #1;
      total++;
      if ({if0.enc_ready, bz0} !== 2'b10) begin
         bad++;
         $display("FAIL bp_next_accept got=%b exp=10", {if0.enc_ready, bz0});
      end
      tick();
      if0.enc_valid = 1'b0;
      #1;
      total++;
      if ({bz0, rf0, ri0} !== {1'b1, 1'b1, 4'd0}) begin
         bad++;
         $display("FAIL bp_started busy=%b first=%b idx=%0d", bz0, rf0, ri0);
      end
      k = 0;
      while (!if0.res_valid && k < 30) begin
         tick();
         k++;
      end
      total++;
      if (if0.res_data !== CT128 || if0.res_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_second v=%b got=%h exp=%h", if0.res_valid, if0.res_data, CT128);
      end
      if0.res_ready = 1'b1;
      tick();
      if0.res_ready = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid();
      logic seen;
      seen = 1'b0;
      if0.enc_data = PT;
      if0.enc_valid = 1'b1;
      #1;
      tick();
      if0.enc_valid = 1'b0;
      #1;
      repeat (5) tick();
      total++;
      if (ri0 !== 4'd5) begin
         bad++;
         $display("FAIL rmid_round got=%0d exp=5", ri0);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({bz0, if0.res_valid, if0.enc_ready, rd0, rf0, rl0, ri0, rki0, rs0, if0.res_data} !== '0) begin
         bad++;
         $display("FAIL rmid_outputs busy=%b v=%b idx=%0d state=%h res=%h exp=0",
                  bz0, if0.res_valid, ri0, rs0, if0.res_data);
      end
      tick();
      rst = 1'b0;
      #1;
      repeat (15) begin
         if (if0.res_valid || bz0) seen = 1'b1;
         tick();
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL rmid_no_result got=%b exp=0", seen);
      end
      test_decrypt();
   endtask

   task automatic test_aes256();
      if2.enc_data = PT;
      if2.enc_valid = 1'b1;
      #1;
      tick();
      if2.enc_valid = 1'b0;
      #1;
      for (int r = 0; r <= 14; r++) begin
         total++;
         if ({ri2, rki2, rf2, rl2, if2.res_valid} !==
             {4'(r), 4'(r), (r == 0), (r == 14), 1'b0}) begin
            bad++;
            $display("FAIL k256_round r=%0d idx=%0d kidx=%0d f=%b l=%b v=%b",
                     r, ri2, rki2, rf2, rl2, if2.res_valid);
         end
         tick();
      end
      total++;
      if ({if2.res_valid, if2.res_is_dec, if2.res_data} !== {1'b1, 1'b0, CT256}) begin
         bad++;
         $display("FAIL k256_result v=%b dec=%b got=%h exp=%h", if2.res_valid, if2.res_is_dec, if2.res_data, CT256);
      end
      if2.res_ready = 1'b1;
      tick();
      if2.res_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if0.enc_valid = 1'b0;
      if0.enc_data = '0;
      if0.dec_valid = 1'b0;
      if0.dec_data = '0;
      if0.res_ready = 1'b0;
      if2.enc_valid = 1'b0;
      if2.enc_data = '0;
      if2.dec_valid = 1'b0;
      if2.dec_data = '0;
      if2.res_ready = 1'b0;
      rk0 = expand(K128, 4);
      rk2 = expand(K256, 8);
      test_reset();
      test_encrypt();
      test_decrypt();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_aes256();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1);
   end

endmodule
